// File: rtl/demux14x16_pkg.sv
// Shared constants and per-FIFO occupancy state for the demux14x16 distribution block.
package demux_pkg;

    localparam int N_DEST = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] DEST_RF  = 2'd0;
    localparam logic [SEL_W-1:0] DEST_MEM = 2'd1;
    localparam logic [SEL_W-1:0] DEST_IO  = 2'd2;
    localparam logic [SEL_W-1:0] DEST_DBG = 2'd3;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_e;

    // Occupancy state is a pure function of the count; no separate register holds it.
    function automatic fifo_state_e fifo_state(input int count, input int depth);
        if (count == 0)
            return FIFO_EMPTY;
        else if (count >= depth)
            return FIFO_FULL;
        else
            return FIFO_PARTIAL;
    endfunction

endpackage

// File: rtl/demux14x16_if.sv
// Input stream and four output handshakes of demux14x16; slave is the block side.
interface demux14x16_if
    import demux_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [SEL_W-1:0]    cntrl;
    logic [WIDTH-1:0]    din;
    logic [N_DEST-1:0]   out_valid;
    logic [N_DEST-1:0]   out_ready;
    logic [WIDTH-1:0]    dout0;
    logic [WIDTH-1:0]    dout1;
    logic [WIDTH-1:0]    dout2;
    logic [WIDTH-1:0]    dout3;

    modport master (
        output in_valid, cntrl, din, out_ready,
        input  in_ready, out_valid, dout0, dout1, dout2, dout3
    );

    modport slave (
        input  in_valid, cntrl, din, out_ready,
        output in_ready, out_valid, dout0, dout1, dout2, dout3
    );
endinterface

// File: rtl/demux14x16_fifo.sv
// Single-channel synchronous FIFO; occupancy state derived from the count.
//   state        | meaning
//   FIFO_EMPTY   | count == 0, head invalid
//   FIFO_PARTIAL | 0 < count < DEPTH, push and pop both allowed
//   FIFO_FULL    | count == DEPTH, push refused
module demux_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    fifo_state_e      state;
    logic             do_push;
    logic             do_pop;

    assign state   = fifo_state(int'(count), DEPTH);
    assign empty   = (state == FIFO_EMPTY);
    assign full    = (state == FIFO_FULL);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux14x16.sv
// Buffered 1-to-4 demultiplexer: steers each input word into a per-destination FIFO.
// Optional pop counters per channel are enabled with DEMUX14X16_STATS_EN.
module demux14x16
    import demux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    demux14x16_if.slave  bus
`ifdef DEMUX14X16_STATS_EN
    ,
    input  logic         stats_clr,
    output logic [31:0]  xfer_cnt
`endif
);
    logic [N_DEST-1:0] push;
    logic [N_DEST-1:0] pop;
    logic [N_DEST-1:0] empty;
    logic [N_DEST-1:0] full;
    logic [WIDTH-1:0]  head   [N_DEST];
    logic [WIDTH-1:0]  masked [N_DEST];

    // in_ready depends only on cntrl and registered full flags, never on out_ready.
    assign bus.in_ready  = ~full[bus.cntrl];
    assign bus.out_valid = ~empty;

    for (genvar k = 0; k < N_DEST; k++) begin : g_dest
        assign push[k]   = bus.in_valid && bus.in_ready && (bus.cntrl == SEL_W'(k));
        assign pop[k]    = bus.out_ready[k] && !empty[k];
        assign masked[k] = empty[k] ? '0 : head[k];

        demux_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .din   (bus.din),
            .pop   (pop[k]),
            .dout  (head[k]),
            .empty (empty[k]),
            .full  (full[k])
        );
    end

    assign bus.dout0 = masked[DEST_RF];
    assign bus.dout1 = masked[DEST_MEM];
    assign bus.dout2 = masked[DEST_IO];
    assign bus.dout3 = masked[DEST_DBG];

`ifdef DEMUX14X16_STATS_EN
    logic [7:0] cnt [N_DEST];

    // A clear wins over a pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_DEST; k++)
                cnt[k] <= '0;
        end else if (stats_clr) begin
            for (int k = 0; k < N_DEST; k++)
                cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N_DEST; k++)
                if (pop[k])
                    cnt[k] <= cnt[k] + 8'd1;
        end
    end

    assign xfer_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule
